// File: rtl/fir_i2s_tx.sv
// Mono I2S transmitter: requantizes a Q30 filter word to 16 bits with rounding and
// saturation, holds one sample, and sends it in both slots of every 32-bit frame.
module fir_i2s_tx #(
   parameter int BCLK_DIV = 4,
   parameter int SHIFT    = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        clip,
   output logic        underrun
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);
   localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

   logic [DW-1:0]       div_cnt;
   logic [4:0]          bit_cnt;
   logic [4:0]          bit_nxt;
   logic [15:0]         hold;
   logic                hold_full;
   logic [15:0]         word;
   logic [15:0]         load_word;
   logic signed [32:0]  rnd_sum;
   logic signed [32:0]  rnd_shift;
   logic [15:0]         sat_word;
   logic                sat_clip;
   logic                tc;
   logic                fall;
   logic                frame_start;
   logic                accept;

   assign din_ready   = ~hold_full;
   assign accept      = din_valid & ~hold_full;
   assign tc          = (div_cnt == DIV_TC);
   assign fall        = tc & bclk;
   assign frame_start = fall & (bit_cnt == 5'd31);
   assign bit_nxt     = bit_cnt + 5'd1;
   assign load_word   = hold_full ? hold : 16'h0000;

   // Round half toward +inf, then clamp to the 16-bit signed range.
   always_comb begin
      rnd_sum   = $signed({din[31], din}) + RND;
      rnd_shift = rnd_sum >>> SHIFT;
      sat_word  = rnd_shift[15:0];
      sat_clip  = 1'b0;
      if (rnd_shift > 33'sd32767) begin
         sat_word = 16'h7FFF;
         sat_clip = 1'b1;
      end else if (rnd_shift < -33'sd32768) begin
         sat_word = 16'h8000;
         sat_clip = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         bclk      <= 1'b0;
         bit_cnt   <= 5'd31;
         lrclk     <= 1'b0;
         sdata     <= 1'b0;
         word      <= 16'h0000;
         hold      <= 16'h0000;
         hold_full <= 1'b0;
         clip      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         div_cnt  <= tc ? '0 : div_cnt + 1'b1;
         clip     <= 1'b0;
         underrun <= 1'b0;
         if (tc) bclk <= ~bclk;

         if (fall) begin
            bit_cnt <= bit_nxt;
            // Word select flips one BCLK ahead of the slot's MSB.
            lrclk   <= (bit_nxt >= 5'd15) && (bit_nxt <= 5'd30);
            if (frame_start) begin
               word     <= load_word;
               sdata    <= load_word[15];
               underrun <= ~hold_full;
            end else begin
               sdata <= word[4'd15 - bit_nxt[3:0]];
            end
         end

         // A frame load and an acceptance can only coincide when the register was empty.
         if (accept) begin
            hold      <= sat_word;
            hold_full <= 1'b1;
            clip      <= sat_clip;
         end else if (frame_start) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_i2s_tx.sv
// Randomized bench for fir_i2s_tx against a time-based behavioural model of the I2S frame.
module tb_fir_i2s_tx;
   localparam int B = 4;
   localparam int S = 15;
   localparam int FRAME = 64 * B;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din = '0;
   logic        din_valid = 1'b0;
   logic        din_ready, bclk, lrclk, sdata, clip, underrun;

   fir_i2s_tx #(.BCLK_DIV(B), .SHIFT(S)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .clip(clip), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: t counts clk edges since reset release
   int          t = 0;
   bit          m_hf = 0;
   logic [15:0] m_hold = '0;
   logic [15:0] m_word = '0;
   bit          m_clip = 0;
   bit          m_und = 0;
   bit          m_acc = 0;
   int          fs_count = 0;
   logic [31:0] cap = '0;
   logic [31:0] frames [0:63];
   int          clip_cnt = 0;
   int          und_cnt = 0;
   int          sdata_hi = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [16:0] quant(input logic [31:0] d);
      longint v;
      v = longint'($signed(d));
      v = (v + (longint'(1) << (S - 1))) >>> S;
      if (v > 32767)  return {1'b1, 16'h7FFF};
      if (v < -32768) return {1'b1, 16'h8000};
      return {1'b0, v[15:0]};
   endfunction

   function automatic int bitn_of(input int tt);
      return ((tt / (2 * B)) + 31) % 32;
   endfunction

   task automatic model_edge(input bit rst, input bit v, input logic [31:0] d);
      logic [16:0] q;
      bit acc;
      m_acc = 0;
      if (!rst) begin
         t = 0; m_hf = 0; m_hold = '0; m_word = '0; m_clip = 0; m_und = 0; fs_count = 0;
         return;
      end
      t++;
      acc = v && !m_hf;
      m_clip = 0;
      m_und = 0;
      if ((t % (2 * B)) == 0 && bitn_of(t) == 0) begin
         m_word = m_hf ? m_hold : 16'h0000;
         m_und = !m_hf;
         m_hf = 0;
         fs_count++;
      end
      if (acc) begin
         q = quant(d);
         m_hold = q[15:0];
         m_clip = q[16];
         m_hf = 1;
         m_acc = 1;
      end
   endtask

   task automatic step(input bit rst, input bit v, input logic [31:0] d);
      int bn;
      @(negedge clk);
      bn = bitn_of(t);
      check_eq("bclk", 32'(bclk), 32'((t / B) % 2));
      check_eq("lrclk", 32'(lrclk), 32'(bn >= 15 && bn <= 30));
      check_eq("sdata", 32'(sdata), 32'(m_word[15 - (bn % 16)]));
      check_eq("din_ready", 32'(din_ready), 32'(!m_hf));
      check_eq("clip", 32'(clip), 32'(m_clip));
      check_eq("underrun", 32'(underrun), 32'(m_und));
      if (clip) clip_cnt++;
      if (underrun) und_cnt++;
      if (sdata) sdata_hi++;
      if (t > 0 && (t % (2 * B)) == 0) begin
         cap[31 - bn] = sdata;
         if (bn == 31 && fs_count < 64) frames[fs_count] = cap;
      end
      rst_n = rst;
      din_valid = v;
      din = d;
      @(posedge clk);
      model_edge(rst, v, d);
   endtask

   function automatic logic [31:0] rand_din();
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return 32'($signed($urandom_range(0, 2_000_000)) - 1_000_000);
         2: return 32'h7FFF_FFFF - $urandom_range(0, 40000);
         3: return 32'h8000_0000 + $urandom_range(0, 40000);
         default: return 32'($signed($urandom_range(0, 131072)) - 65536);
      endcase
   endfunction

   logic [31:0] dir_din [0:6];
   logic [15:0] dir_exp [0:6];

   initial begin
      int sent;
      bit found;
      bit v;
      dir_din = '{32'd32768, 32'd16384, -32'sd16384, -32'sd16385, 32'h7FFF_FFFF, 32'h8000_0000, 32'h091A_0000};
      dir_exp = '{16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
      for (int i = 0; i < 64; i++) frames[i] = 32'hDEAD_BEEF;

      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), $urandom);

      // Directed samples, one per frame: sample j rides in frame j+2.
      sent = 0;
      clip_cnt = 0;
      for (int c = 0; c < FRAME * 8 + 8; c++) begin
         v = (sent < 7) && !m_hf && (fs_count == sent + 1);
         step(1'b1, v, v ? dir_din[sent] : $urandom);
         if (m_acc) sent++;
      end
      check_eq("directed_accepts", 32'(sent), 32'd7);
      check_eq("directed_clip_pulses", 32'(clip_cnt), 32'd2);
      check_eq("frame1_underrun", frames[1], 32'h0);
      for (int j = 0; j < 7; j++)
         check_eq($sformatf("frame_dir%0d", j), frames[j + 2], {dir_exp[j], dir_exp[j]});

      // Random traffic, including back-to-back valids that must stall.
      for (int c = 0; c < 4000; c++)
         step(1'b1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, rand_din());

      // Reset landing at bit 20 while a sample is held.
      found = 0;
      for (int c = 0; c < 2000 && !found; c++) begin
         step(1'b1, 1'b1, rand_din());
         found = (bitn_of(t) == 20) && m_hf;
      end
      check_eq("reset_setup_found", 32'(found), 32'd1);
      step(1'b0, 1'b1, rand_din());

      und_cnt = 0;
      sdata_hi = 0;
      for (int c = 0; c < 3 * FRAME; c++) step(1'b1, 1'b0, $urandom);
      check_eq("idle_underruns", 32'(und_cnt), 32'd3);
      check_eq("idle_sdata_high", 32'(sdata_hi), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
